// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low digit patterns (g..a), blank
// pattern and the capture output FSM state type.
package seg7_pkg;

  // Indexed by hex digit value, so SEG_HEX[4'hA] is the pattern for 'A'.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/seg7_pat2hex.sv
// Combinational decoder from an active-low 7-segment pattern back to a hex
// nibble, flagging legal digits and the blank pattern separately.
module seg7_pat2hex
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nibble_o,
  output logic       legal_o,
  output logic       blank_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat_i == SEG_HEX[i]) begin
        nibble_o = 4'(i);
        legal_o  = 1'b1;
      end
    end
  end

  assign blank_o = (pat_i == SEG_BLANK);

endmodule

// File: rtl/seg7_capture.sv
// Stability-filtered 7-segment capture with valid/ready output.
// Define SEG7_CAP_ERR_EN to report illegal patterns as items with out_err=1.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_i,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_nibble,
  output logic       out_err,
  output logic       ovf
);

  logic [6:0] samp_q, samp_d;
  logic [6:0] last_q, last_d;
  logic [7:0] stab_cnt_q, stab_cnt_d;
  out_state_e state_q, state_d;
  logic [3:0] nibble_q, nibble_d;
  logic       ovf_q, ovf_d;
`ifdef SEG7_CAP_ERR_EN
  logic       err_q, err_d;
`endif

  logic [3:0] pat_nibble;
  logic       pat_legal;
  logic       pat_blank;
  logic       unchanged;
  logic       accept;
  logic       emit;
  logic       handshake;

  seg7_pat2hex u_pat2hex (
    .pat_i    (samp_q),
    .nibble_o (pat_nibble),
    .legal_o  (pat_legal),
    .blank_o  (pat_blank)
  );

  always_comb begin
    samp_d     = seg_i;
    last_d     = last_q;
    stab_cnt_d = stab_cnt_q;
    state_d    = state_q;
    nibble_d   = nibble_q;
    ovf_d      = ovf_q;
`ifdef SEG7_CAP_ERR_EN
    err_d      = err_q;
`endif

    unchanged = (seg_i == samp_q);
    if (!unchanged)
      stab_cnt_d = 8'd0;
    else if (stab_cnt_q != 8'(STABLE_CYCLES))
      stab_cnt_d = stab_cnt_q + 8'd1;

    // Acceptance fires once per stable run: the counter then saturates past STABLE_CYCLES-1.
    accept = unchanged && (stab_cnt_q == 8'(STABLE_CYCLES - 1)) && (samp_q != last_q);
    if (accept)
      last_d = samp_q;

`ifdef SEG7_CAP_ERR_EN
    emit = accept && !pat_blank;
`else
    emit = accept && pat_legal;
`endif

    handshake = (state_q == FULL) && out_ready;

    case (state_q)
      EMPTY: begin
        if (emit) begin
          state_d  = FULL;
          nibble_d = pat_legal ? pat_nibble : 4'h0;
`ifdef SEG7_CAP_ERR_EN
          err_d    = !pat_legal;
`endif
        end
      end
      FULL: begin
        if (emit && handshake) begin
          nibble_d = pat_legal ? pat_nibble : 4'h0;
`ifdef SEG7_CAP_ERR_EN
          err_d    = !pat_legal;
`endif
        end else if (handshake) begin
          state_d = EMPTY;
        end else if (emit) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= SEG_BLANK;
      last_q     <= SEG_BLANK;
      stab_cnt_q <= 8'd0;
      state_q    <= EMPTY;
      nibble_q   <= 4'h0;
      ovf_q      <= 1'b0;
`ifdef SEG7_CAP_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      samp_q     <= samp_d;
      last_q     <= last_d;
      stab_cnt_q <= stab_cnt_d;
      state_q    <= state_d;
      nibble_q   <= nibble_d;
      ovf_q      <= ovf_d;
`ifdef SEG7_CAP_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_nibble = nibble_q;
  assign ovf        = ovf_q;
`ifdef SEG7_CAP_ERR_EN
  assign out_err    = err_q;
`else
  assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: a queue of expected items is filled
// as patterns are driven and drained whenever the DUT completes a handshake.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_i;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_nibble;
  logic       out_err;
  logic       ovf;

  typedef struct packed {
    logic       err;
    logic [3:0] nib;
  } item_t;

  item_t expQ[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    popped     = 0;
  int    popBase;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_i      (seg_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_nibble (out_nibble),
    .out_err    (out_err),
    .ovf        (ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] pat, input int cycles, input bit report, input logic [3:0] nib, input logic err);
    item_t it;
    seg_i = pat;
    if (report) begin
      it.err = err;
      it.nib = nib;
      expQ.push_back(it);
    end
    tick(cycles);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || out_valid) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget)
      checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  // Scoreboard: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_item", {27'b0, out_err, out_nibble}, 32'h0);
        checkOutput("queue_nonempty", expQ.size(), 1);
      end else begin
        item_t e;
        e = expQ.pop_front();
        checkOutput("item_nibble", out_nibble, e.nib);
        checkOutput("item_err", out_err, e.err);
        popped++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    seg_i = 7'h7F;
    out_ready = 1'b1;
    tick(3);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_nibble", out_nibble, 0);
    checkOutput("rst_err", out_err, 0);
    checkOutput("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick(2);

    $display("[TB] digit 2 latency");
    applyStimulus(7'b0100100, 4, 1'b1, 4'h2, 1'b0);
    checkOutput("latency_early", out_valid, 0);
    tick(1);
    checkOutput("latency_valid", out_valid, 1);
    checkOutput("latency_nibble", out_nibble, 4'h2);
    tick(1);
    checkOutput("valid_after_hs", out_valid, 0);
    tick(4);

    $display("[TB] glitch filter");
    popBase = popped;
    applyStimulus(7'b1111001, 3, 1'b0, 4'h0, 1'b0);
    applyStimulus(7'b0110000, 8, 1'b1, 4'h3, 1'b0);
    waitDrain(50);
    checkOutput("glitch_count", popped - popBase, 1);

    $display("[TB] repeat after blank");
    popBase = popped;
    applyStimulus(7'b0000000, 8, 1'b1, 4'h8, 1'b0);
    applyStimulus(7'h7F,      8, 1'b0, 4'h0, 1'b0);
    applyStimulus(7'b0000000, 8, 1'b1, 4'h8, 1'b0);
    waitDrain(50);
    checkOutput("blank_count", popped - popBase, 2);

    $display("[TB] overflow");
    out_ready = 1'b0;
    applyStimulus(7'b1000110, 8, 1'b1, 4'hC, 1'b0);
    applyStimulus(7'b0000110, 8, 1'b0, 4'h0, 1'b0);
    checkOutput("ovf_valid", out_valid, 1);
    checkOutput("ovf_hold_nibble", out_nibble, 4'hC);
    checkOutput("ovf_set", ovf, 1);
    out_ready = 1'b1;
    tick(1);
    checkOutput("ovf_drop_valid", out_valid, 0);
    checkOutput("ovf_sticky", ovf, 1);
    checkOutput("ovf_queue", expQ.size(), 0);

    $display("[TB] illegal pattern");
    popBase = popped;
    applyStimulus(7'h7F, 8, 1'b0, 4'h0, 1'b0);
`ifdef SEG7_CAP_ERR_EN
    applyStimulus(7'b1010101, 8, 1'b1, 4'h0, 1'b1);
    waitDrain(50);
    checkOutput("illegal_count", popped - popBase, 1);
`else
    applyStimulus(7'b1010101, 8, 1'b0, 4'h0, 1'b0);
    waitDrain(50);
    checkOutput("illegal_count", popped - popBase, 0);
    checkOutput("illegal_valid", out_valid, 0);
`endif

    $display("[TB] reset with item pending");
    out_ready = 1'b0;
    applyStimulus(7'b0001110, 8, 1'b1, 4'hF, 1'b0);
    checkOutput("pend_valid", out_valid, 1);
    checkOutput("pend_nibble", out_nibble, 4'hF);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expQ.delete();
    checkOutput("rst2_valid", out_valid, 0);
    checkOutput("rst2_nibble", out_nibble, 0);
    checkOutput("rst2_err", out_err, 0);
    checkOutput("rst2_ovf", ovf, 0);
    applyStimulus(7'b0001110, 4, 1'b1, 4'hF, 1'b0);
    checkOutput("rerun_early", out_valid, 0);
    tick(1);
    checkOutput("rerun_valid", out_valid, 1);
    checkOutput("rerun_nibble", out_nibble, 4'hF);
    out_ready = 1'b1;
    waitDrain(50);
    checkOutput("final_queue", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the board's hex-to-7-segment display driver. Samples an active-low 7-segment pattern bus (a display being driven, or a loopback of our own driver output). Requires each pattern to hold stable for a programmable number of cycles, then decodes it back to a 4-bit hex value. Results go out through a valid/ready handshake to downstream logic such as a checker, logger or UART bridge.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high, sampled on rising edge of clk
- seg_i  in  7  segment pattern, active-low; bit0=a … bit6=g
- out_valid  out  1  decoded value pending
- out_ready  in  1  downstream accepts when out_valid && out_ready at a rising edge
- out_nibble  out  4  decoded hex value 0x0–0xF
- out_err  out  1  pending item is an illegal pattern (meaningful only when SEG7_CAP_ERR_EN is defined)
- ovf  out  1  sticky; a new result was dropped because the previous one was still pending

## Operation
- Decode table (seg_i, g..a): 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
- Blank (7'h7F) is a legal, non-reported pattern. Every other unlisted pattern is illegal.
- Input register samp captures seg_i every cycle.
- stab_cnt (8 bit) clears when samp changes and increments while samp is unchanged; it saturates at STABLE_CYCLES.
- A pattern is accepted on the cycle stab_cnt reaches STABLE_CYCLES-1 with samp unchanged, provided samp != last.
  - On acceptance, last <= samp.
  - Blank: last is updated and nothing is emitted, so a digit repeated after a blank is reported again.
  - Legal digit: emit an item with out_nibble = decoded value and out_err = 0.
  - Illegal pattern: see Configuration.
- Output FSM has two states:
  - EMPTY to FULL on emit.
  - FULL to EMPTY on handshake.
  - FULL with handshake and emit in the same cycle: stay FULL and load the new item. ovf is not set.
  - FULL with emit and no handshake: keep the old item and set ovf.
- out_nibble and out_err hold stable while out_valid is high.
- ovf clears only on rst.

## Timing
- Reset values: out_valid=0, out_nibble=0, out_err=0, ovf=0, samp=7'h7F, last=7'h7F, stab_cnt=0, FSM=EMPTY.
- Latency: if seg_i holds a new pattern from before rising edge 0, out_valid is high after edge STABLE_CYCLES (STABLE_CYCLES+1 edges total). Default: after the 5th edge.
- A glitch shorter than STABLE_CYCLES+1 cycles is never reported. The counter restarts from 0 on every change.
- out_ready is not combinationally coupled to any output. out_valid depends only on registered state.
- rst asserted mid-pattern or with an item pending discards all state. The first pattern after rst release needs the full latency again.
- Throughput: at most one item per STABLE_CYCLES+1 cycles.

## Configuration
- SEG7_CAP_ERR_EN defined:
  - An accepted illegal pattern emits an item with out_err=1 and out_nibble=0.
  - It participates in handshake and ovf like a digit.
- SEG7_CAP_ERR_EN undefined:
  - An illegal pattern updates last and is silently discarded.
  - out_err is tied to 0.

## Structure
- Shared package seg7_pkg holds:
  - the 16-entry segment pattern constants, shared with the display driver;
  - SEG_BLANK = 7'h7F;
  - the output FSM state typedef (EMPTY, FULL).
- One sub-module seg7_pat2hex, combinational: 7-bit pattern in; nibble, legal and blank flags out.
- Stability filter and handshake FSM stay in the top module.

## Test plan
- Reset, then seg_i=0100100 held 10 cycles, out_ready=1 → one item, out_nibble=2, out_valid high after edge 4 after the change, low after handshake.
- seg_i=1111001 for 3 cycles, then 0110000 held → only 3 reported; 1 is a glitch and is filtered.
- Sequence 8 (0000000), blank, 8, each held 8 cycles → two items with out_nibble=8.
- out_ready=0, then patterns C then E, each held 8 cycles → item stays C, ovf=1. Raise out_ready → C accepted, out_valid drops.
- seg_i=1111111 then 1010101 held → with SEG7_CAP_ERR_EN: item with out_err=1, out_nibble=0. Without: no item.
- Item F pending, rst pulsed 1 cycle → all outputs 0 next cycle. F re-presented → reported again after 5 edges.
